// File: rtl/ftdi_device_emulator.sv
// FT245-style device emulator: host RD#/WR# strobes service two byte FIFOs whose
// far ends are exposed to the PC side as valid/ready streams, with sticky error flags.
module ftdi_device_emulator #(
    parameter int DEPTH = 16,
    parameter int GAP   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     ftdi_rd,
    input  logic                     ftdi_wr,
    input  logic                     adbus_tri,
    input  logic [7:0]               adbus_in,
    output logic [7:0]               adbus_out,
    output logic                     rxf,
    output logic                     txe,
    input  logic                     pc_wr_valid,
    input  logic [7:0]               pc_wr_data,
    output logic                     pc_wr_ready,
    output logic                     pc_rd_valid,
    output logic [7:0]               pc_rd_data,
    input  logic                     pc_rd_ready,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     err_rd,
    output logic                     err_wr,
    output logic                     err_both
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP + 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

    logic          flush;
    logic          rd_prev, wr_prev;
    logic          rd_fall, rd_rise, wr_fall, wr_rise;
    logic          both_low;
    logic [GW-1:0] rd_gap, wr_gap;
    logic          rd_active, wr_active;
    logic          rd_avail, wr_avail;
    logic          rd_start, wr_start;
    logic          rx_push, rx_pop, tx_push, tx_pop;
    logic [7:0]    hold;

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;

    assign flush    = reset | clear;
    assign rd_fall  = rd_prev & ~ftdi_rd;
    assign rd_rise  = ~rd_prev & ftdi_rd;
    assign wr_fall  = wr_prev & ~ftdi_wr;
    assign wr_rise  = ~wr_prev & ftdi_wr;
    assign both_low = ~ftdi_rd & ~ftdi_wr;

    // A strobe may only start a transfer when its FIFO side is ready and the
    // post-strobe gap has elapsed; rxf/txe are this readiness, masked while the
    // strobe is low and during the rising-edge cycle itself.
    assign rd_avail = (rx_count != '0) && (rd_gap == '0);
    assign wr_avail = (tx_count != FULL) && (wr_gap == '0);
    assign rxf      = ~rd_avail | ~ftdi_rd | rd_rise;
    assign txe      = ~wr_avail | ~ftdi_wr | wr_rise;

    assign rd_start = rd_fall & rd_avail & ~both_low;
    assign wr_start = wr_fall & wr_avail & ~both_low;

    // The head byte is presented in the falling-edge cycle already, so the host
    // can sample it in its first low cycle.
    always_comb begin
        adbus_out = 8'h00;
        if ((rd_start | rd_active) && !ftdi_rd && !both_low) begin
            adbus_out = rx_mem[rx_rptr];
        end
    end

    assign pc_wr_ready = (rx_count != FULL);
    assign rx_push     = pc_wr_valid & pc_wr_ready;
    assign rx_pop      = rd_rise & rd_active & (rx_count != '0);

    assign pc_rd_valid = (tx_count != '0);
    assign pc_rd_data  = tx_mem[tx_rptr];
    assign tx_pop      = pc_rd_valid & pc_rd_ready;
    assign tx_push     = wr_rise & wr_active & (tx_count != FULL);

    // Strobe history resets high so a strobe held low through reset release
    // is seen as a fresh falling edge.
    always_ff @(posedge clock) begin
        if (flush) begin
            rd_prev <= 1'b1;
            wr_prev <= 1'b1;
        end else begin
            rd_prev <= ftdi_rd;
            wr_prev <= ftdi_wr;
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            rd_active <= 1'b0;
            wr_active <= 1'b0;
            rd_gap    <= '0;
            wr_gap    <= '0;
        end else begin
            if (both_low || rd_rise) begin
                rd_active <= 1'b0;
            end else if (rd_start) begin
                rd_active <= 1'b1;
            end

            if (both_low || wr_rise) begin
                wr_active <= 1'b0;
            end else if (wr_start) begin
                wr_active <= 1'b1;
            end

            if (rd_rise) begin
                rd_gap <= GAP_LOAD;
            end else if (rd_gap != '0) begin
                rd_gap <= rd_gap - GW'(1);
            end

            if (wr_rise) begin
                wr_gap <= GAP_LOAD;
            end else if (wr_gap != '0) begin
                wr_gap <= wr_gap - GW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            err_rd   <= 1'b0;
            err_wr   <= 1'b0;
            err_both <= 1'b0;
            hold     <= 8'h00;
        end else begin
            if (rd_fall && !rd_avail && !both_low) begin
                err_rd <= 1'b1;
            end
            if (wr_fall && !wr_avail && !both_low) begin
                err_wr <= 1'b1;
            end
            if (both_low) begin
                err_both <= 1'b1;
            end
            if (!ftdi_wr && adbus_tri) begin
                hold <= adbus_in;
            end
        end
    end

    // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clock) begin
        if (flush) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + AW'(1);
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + AW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + AW'(1);
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + AW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!flush && rx_push) begin
            rx_mem[rx_wptr] <= pc_wr_data;
        end
        if (!flush && tx_push) begin
            tx_mem[tx_wptr] <= hold;
        end
    end

endmodule

// File: tb/tb_ftdi_device_emulator.sv
// Randomized bench for ftdi_device_emulator: host and PC traffic are checked
// against byte queues and sticky error bits derived from the protocol rules.
module tb_ftdi_device_emulator;

    localparam int DEPTH = 16;
    localparam int GAP   = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock;
    logic          reset, clear;
    logic          ftdi_rd, ftdi_wr, adbus_tri;
    logic [7:0]    adbus_in, adbus_out;
    logic          rxf, txe;
    logic          pc_wr_valid, pc_wr_ready;
    logic [7:0]    pc_wr_data;
    logic          pc_rd_valid, pc_rd_ready;
    logic [7:0]    pc_rd_data;
    logic [CW-1:0] rx_count, tx_count;
    logic          err_rd, err_wr, err_both;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    ftdi_device_emulator #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .ftdi_rd(ftdi_rd), .ftdi_wr(ftdi_wr),
        .adbus_tri(adbus_tri), .adbus_in(adbus_in), .adbus_out(adbus_out),
        .rxf(rxf), .txe(txe),
        .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data), .pc_wr_ready(pc_wr_ready),
        .pc_rd_valid(pc_rd_valid), .pc_rd_data(pc_rd_data), .pc_rd_ready(pc_rd_ready),
        .rx_count(rx_count), .tx_count(tx_count),
        .err_rd(err_rd), .err_wr(err_wr), .err_both(err_both)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        rx_q.delete();
        tx_q.delete();
    endtask

    task automatic pc_push(input logic [7:0] b);
        pc_wr_valid = 1'b1;
        pc_wr_data  = b;
        step();
        pc_wr_valid = 1'b0;
        pc_wr_data  = 8'($urandom);
    endtask

    task automatic pc_pop(output logic [7:0] b);
        b = pc_rd_data;
        pc_rd_ready = 1'b1;
        step();
        pc_rd_ready = 1'b0;
    endtask

    // Host read: wait (bounded) for RXF# low, hold RD# low two cycles and
    // sample the bus in the first low cycle.
    task automatic host_read(output logic [7:0] data, output bit ok);
        for (int i = 0; i < 32 && rxf !== 1'b0; i++) step();
        ok = (rxf === 1'b0);
        ftdi_rd = 1'b0;
        #1 data = adbus_out;
        step();
        step();
        ftdi_rd = 1'b1;
        step();
    endtask

    // Host write: the bus value changes between the two low cycles; the
    // last value is the one that must land in the FIFO.
    task automatic host_write(input logic [7:0] b_first, input logic [7:0] b_last, output bit ok);
        for (int i = 0; i < 32 && txe !== 1'b0; i++) step();
        ok = (txe === 1'b0);
        ftdi_wr   = 1'b0;
        adbus_tri = 1'b1;
        adbus_in  = b_first;
        step();
        adbus_in  = b_last;
        step();
        ftdi_wr   = 1'b1;
        adbus_tri = 1'b0;
        adbus_in  = 8'($urandom);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        vectors++; if (rxf !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rxf: got %b want 1", rxf); end
        vectors++; if (txe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_txe: got %b want 0", txe); end
        vectors++; if (adbus_out !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_adbus: got %h want 00", adbus_out); end
        vectors++; if (pc_wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_wr_ready: got %b want 1", pc_wr_ready); end
        vectors++; if (pc_rd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_valid: got %b want 0", pc_rd_valid); end
        vectors++; if (rx_count !== '0 || tx_count !== '0) begin miscompares++; $display("[TB] FAIL reset_counts: got %0d/%0d want 0/0", rx_count, tx_count); end
        vectors++; if ({err_rd, err_wr, err_both} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_errs: got %b want 000", {err_rd, err_wr, err_both}); end
    endtask

    task automatic test_rx_basic();
        logic [7:0] d;
        bit ok;
        do_clear();
        pc_push(8'hA5);
        pc_push(8'h3C);
        vectors++; if (rx_count !== CW'(2)) begin miscompares++; $display("[TB] FAIL rx_count_2: got %0d want 2", rx_count); end
        host_read(d, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_wait1: rxf got %b want 0", rxf); end
        vectors++; if (d !== 8'hA5) begin miscompares++; $display("[TB] FAIL rx_data1: got %h want a5", d); end
        vectors++; if (rx_count !== CW'(1)) begin miscompares++; $display("[TB] FAIL rx_count_1: got %0d want 1", rx_count); end
        vectors++; if (rxf !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_gap_high: got %b want 1", rxf); end
        repeat (GAP) step();
        vectors++; if (rxf !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_gap_end: got %b want 0", rxf); end
        host_read(d, ok);
        vectors++; if (d !== 8'h3C) begin miscompares++; $display("[TB] FAIL rx_data2: got %h want 3c", d); end
        vectors++; if (rx_count !== CW'(0)) begin miscompares++; $display("[TB] FAIL rx_count_0: got %0d want 0", rx_count); end
        repeat (GAP) step();
        vectors++; if (rxf !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_empty_rxf: got %b want 1", rxf); end
    endtask

    task automatic test_tx_basic();
        logic [7:0] d;
        bit ok;
        do_clear();
        host_write(8'h77, 8'h5A, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_wait: txe got %b want 0", txe); end
        vectors++; if (tx_count !== CW'(1)) begin miscompares++; $display("[TB] FAIL tx_count_1: got %0d want 1", tx_count); end
        vectors++; if (pc_rd_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_valid: got %b want 1", pc_rd_valid); end
        pc_pop(d);
        vectors++; if (d !== 8'h5A) begin miscompares++; $display("[TB] FAIL tx_data: got %h want 5a", d); end
        vectors++; if (tx_count !== CW'(0) || pc_rd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_drain: got count %0d valid %b want 0/0", tx_count, pc_rd_valid); end
    endtask

    task automatic test_tx_full();
        logic [7:0] d, b;
        bit ok;
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            host_write(8'($urandom), b, ok);
            tx_q.push_back(b);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_wait %0d: txe got %b want 0", i, txe); end
        end
        repeat (GAP + 1) step();
        vectors++; if (txe !== 1'b1) begin miscompares++; $display("[TB] FAIL full_txe: got %b want 1", txe); end
        vectors++; if (tx_count !== CW'(DEPTH)) begin miscompares++; $display("[TB] FAIL full_count: got %0d want %0d", tx_count, DEPTH); end
        vectors++; if (err_wr !== 1'b0) begin miscompares++; $display("[TB] FAIL full_err_early: got %b want 0", err_wr); end
        ftdi_wr = 1'b0; adbus_tri = 1'b1; adbus_in = 8'hEE;
        step(); step();
        ftdi_wr = 1'b1; adbus_tri = 1'b0;
        step();
        vectors++; if (err_wr !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_err: got %b want 1", err_wr); end
        vectors++; if (tx_count !== CW'(DEPTH)) begin miscompares++; $display("[TB] FAIL overflow_count: got %0d want %0d", tx_count, DEPTH); end
        pc_pop(d);
        b = tx_q.pop_front();
        vectors++; if (d !== b) begin miscompares++; $display("[TB] FAIL full_pop0: got %h want %h", d, b); end
        repeat (GAP) step();
        vectors++; if (txe !== 1'b0) begin miscompares++; $display("[TB] FAIL txe_reopen: got %b want 0", txe); end
        while (tx_q.size() > 0) begin
            pc_pop(d);
            b = tx_q.pop_front();
            vectors++; if (d !== b) begin miscompares++; $display("[TB] FAIL full_drain: got %h want %h", d, b); end
        end
        vectors++; if (err_wr !== 1'b1) begin miscompares++; $display("[TB] FAIL err_wr_sticky: got %b want 1", err_wr); end
        do_clear();
        vectors++; if (err_wr !== 1'b0) begin miscompares++; $display("[TB] FAIL err_wr_clear: got %b want 0", err_wr); end
    endtask

    task automatic test_errors();
        logic [7:0] obs, d, b;
        bit ok;
        do_clear();
        ftdi_rd = 1'b0;
        #1 obs = adbus_out;
        step(); step();
        ftdi_rd = 1'b1;
        step();
        vectors++; if (obs !== 8'h00) begin miscompares++; $display("[TB] FAIL empty_rd_bus: got %h want 00", obs); end
        vectors++; if (err_rd !== 1'b1) begin miscompares++; $display("[TB] FAIL empty_rd_err: got %b want 1", err_rd); end
        vectors++; if (rx_count !== CW'(0)) begin miscompares++; $display("[TB] FAIL empty_rd_count: got %0d want 0", rx_count); end
        b = 8'($urandom);
        pc_push(b);
        repeat (GAP + 1) step();
        ftdi_rd = 1'b0; ftdi_wr = 1'b0;
        #1 obs = adbus_out;
        step(); step();
        ftdi_rd = 1'b1; ftdi_wr = 1'b1;
        step();
        vectors++; if (err_both !== 1'b1) begin miscompares++; $display("[TB] FAIL both_err: got %b want 1", err_both); end
        vectors++; if (obs !== 8'h00) begin miscompares++; $display("[TB] FAIL both_bus: got %h want 00", obs); end
        vectors++; if (rx_count !== CW'(1) || tx_count !== CW'(0)) begin miscompares++; $display("[TB] FAIL both_counts: got %0d/%0d want 1/0", rx_count, tx_count); end
        host_read(d, ok);
        vectors++; if (d !== b || ok !== 1'b1) begin miscompares++; $display("[TB] FAIL both_survivor: got %h ok %b want %h ok 1", d, ok, b); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] b;
        bit ok;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            pc_push(b);
            rx_q.push_back(b);
        end
        for (int i = 0; i < 32 && rxf !== 1'b0; i++) step();
        ftdi_rd = 1'b0;
        step();
        vectors++; if (adbus_out !== rx_q[0]) begin miscompares++; $display("[TB] FAIL midread_bus: got %h want %h", adbus_out, rx_q[0]); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        rx_q.delete();
        vectors++; if (rx_count !== CW'(0) || rxf !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_state: got count %0d rxf %b want 0/1", rx_count, rxf); end
        vectors++; if (adbus_out !== 8'h00) begin miscompares++; $display("[TB] FAIL midreset_bus: got %h want 00", adbus_out); end
        vectors++; if ({err_rd, err_wr, err_both} !== 3'b000) begin miscompares++; $display("[TB] FAIL midreset_errs: got %b want 000", {err_rd, err_wr, err_both}); end
        step();
        vectors++; if (err_rd !== 1'b1) begin miscompares++; $display("[TB] FAIL held_low_edge: got %b want 1", err_rd); end
        ftdi_rd = 1'b1;
        step(); step();
    endtask

    task automatic test_simul_and_wrap();
        logic [7:0] d, b, e;
        bit ok;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            pc_push(b);
            rx_q.push_back(b);
        end
        for (int i = 0; i < 32 && rxf !== 1'b0; i++) step();
        ftdi_rd = 1'b0;
        #1 d = adbus_out;
        step(); step();
        b = 8'($urandom);
        ftdi_rd = 1'b1;
        pc_wr_valid = 1'b1;
        pc_wr_data = b;
        step();
        pc_wr_valid = 1'b0;
        e = rx_q.pop_front();
        rx_q.push_back(b);
        vectors++; if (d !== e) begin miscompares++; $display("[TB] FAIL simul_data: got %h want %h", d, e); end
        vectors++; if (rx_count !== CW'(4)) begin miscompares++; $display("[TB] FAIL simul_count: got %0d want 4", rx_count); end
        for (int i = 0; i < 2 * DEPTH; i++) begin
            b = 8'($urandom);
            pc_push(b);
            rx_q.push_back(b);
            host_read(d, ok);
            e = rx_q.pop_front();
            vectors++; if (d !== e || ok !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap %0d: got %h ok %b want %h", i, d, ok, e); end
        end
    endtask

    task automatic test_random_traffic();
        logic [7:0] d, b, e;
        bit ok;
        do_clear();
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: if (rx_q.size() < DEPTH) begin
                       b = 8'($urandom);
                       pc_push(b);
                       rx_q.push_back(b);
                   end
                1: if (rx_q.size() > 0) begin
                       host_read(d, ok);
                       e = rx_q.pop_front();
                       vectors++; if (d !== e || ok !== 1'b1) begin miscompares++; $display("[TB] FAIL rand_rd %0d: got %h ok %b want %h", i, d, ok, e); end
                   end
                2: if (tx_q.size() < DEPTH) begin
                       b = 8'($urandom);
                       host_write(8'($urandom), b, ok);
                       tx_q.push_back(b);
                       vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL rand_wr_wait %0d: txe got %b want 0", i, txe); end
                   end
                default: if (tx_q.size() > 0) begin
                       pc_pop(d);
                       e = tx_q.pop_front();
                       vectors++; if (d !== e) begin miscompares++; $display("[TB] FAIL rand_pop %0d: got %h want %h", i, d, e); end
                   end
            endcase
            vectors++;
            if (rx_count !== CW'(rx_q.size()) || tx_count !== CW'(tx_q.size())) begin
                miscompares++;
                $display("[TB] FAIL rand_counts %0d: got %0d/%0d want %0d/%0d", i, rx_count, tx_count, rx_q.size(), tx_q.size());
            end
        end
        vectors++; if ({err_rd, err_wr, err_both} !== 3'b000) begin miscompares++; $display("[TB] FAIL rand_errs: got %b want 000", {err_rd, err_wr, err_both}); end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        ftdi_rd = 1'b1; ftdi_wr = 1'b1; adbus_tri = 1'b0; adbus_in = 8'h00;
        pc_wr_valid = 1'b0; pc_wr_data = 8'h00; pc_rd_ready = 1'b0;
        test_reset();
        test_rx_basic();
        test_tx_basic();
        test_tx_full();
        test_errors();
        test_reset_mid_read();
        test_simul_and_wrap();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
